// File: rtl/mem_access_aligner.sv
// Load/store aligner: lane-shifts pipeline accesses onto a DATA_W bus and right-justifies/extends load data.
// Macro ALIGNER_MISALIGN_SPLIT_EN splits bus-word-crossing accesses into two beats instead of raising AdEL/AdES.
module mem_access_aligner #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_sign,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                exc_valid,
  output logic                exc_store,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int BE_W  = 2 * NB;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              exc_valid_q, exc_valid_d;
  logic              exc_store_q, exc_store_d;

  logic [1:0]        req_size_eff;
  logic [OFF_W-1:0]  off;
  logic [3:0]        acc_bytes;
  logic [BE_W-1:0]   lane_mask;
  logic [BE_W-1:0]   be0_w;
  logic [BE_W-1:0]   be1_w;
  logic [ADDR_W-1:0] addr_al;
  logic              split;
  int                tail;

  // Keep the low 8*bytes of v, filling the rest with zeros or the access MSB.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input logic [1:0] sz,
                                               input logic sg);
    logic [DATA_W-1:0] mask;
    logic              msb;
    case (sz)
      2'd0:    begin mask = DATA_W'(64'hFF);        msb = v[7];        end
      2'd1:    begin mask = DATA_W'(64'hFFFF);      msb = v[15];       end
      2'd2:    begin mask = DATA_W'(64'hFFFF_FFFF); msb = v[31];       end
      default: begin mask = '1;                     msb = v[DATA_W-1]; end
    endcase
    return (v & mask) | ((sg && msb) ? ~mask : '0);
  endfunction

  always_comb begin
    req_size_eff = (DATA_W == 32 && req_size == 2'd3) ? 2'd2 : req_size;
    off          = addr_q[OFF_W-1:0];
    acc_bytes    = 4'd1 << size_q;
    lane_mask    = BE_W'((32'd1 << acc_bytes) - 32'd1);
    tail         = NB - int'(off);
    be0_w        = lane_mask << off;
    be1_w        = lane_mask >> tail;
    addr_al      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef ALIGNER_MISALIGN_SPLIT_EN
    split        = (int'(off) + int'(acc_bytes)) > NB;
`else
    split        = 1'b0;
`endif
  end

`ifndef ALIGNER_MISALIGN_SPLIT_EN
  logic [3:0] req_bytes;
  logic       req_misalign;

  always_comb begin
    req_bytes    = 4'd1 << req_size_eff;
    req_misalign = |(req_addr[OFF_W-1:0] & OFF_W'(req_bytes - 4'd1));
  end
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    sign_d      = sign_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    rsp_rdata_d = rsp_rdata_q;
    exc_valid_d = 1'b0;
    exc_store_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size_eff;
          sign_d  = req_sign;
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef ALIGNER_MISALIGN_SPLIT_EN
          state_d = S_BEAT0;
`else
          if (req_misalign) begin
            exc_valid_d = 1'b1;
            exc_store_d = req_we;
          end else begin
            state_d = S_BEAT0;
          end
`endif
        end
      end
      S_BEAT0: begin
        if (mem_ready) begin
          if (split) begin
            lo_d    = mem_rdata >> (8 * int'(off));
            state_d = S_BEAT1;
          end else begin
            if (!we_q) rsp_rdata_d = extend(mem_rdata >> (8 * int'(off)), size_q, sign_q);
            state_d = S_RESP;
          end
        end
      end
      S_BEAT1: begin
        // Second beat supplies the upper bytes of the access; merge before extending.
        if (mem_ready) begin
          if (!we_q) rsp_rdata_d = extend(lo_q | (mem_rdata << (8 * tail)), size_q, sign_q);
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = rsp_rdata_q;
    exc_valid = exc_valid_q;
    exc_store = exc_store_q;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    if (state_q == S_BEAT0) begin
      mem_valid = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_al;
      mem_be    = be0_w[NB-1:0];
      mem_wdata = wdata_q << (8 * int'(off));
    end else if (state_q == S_BEAT1) begin
      mem_valid = 1'b1;
      mem_we    = we_q;
      mem_addr  = addr_al + ADDR_W'(NB);
      mem_be    = be1_w[NB-1:0];
      mem_wdata = wdata_q >> (8 * tail);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      sign_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      rsp_rdata_q <= '0;
      exc_valid_q <= 1'b0;
      exc_store_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      rsp_rdata_q <= rsp_rdata_d;
      exc_valid_q <= exc_valid_d;
      exc_store_q <= exc_store_d;
    end
  end

endmodule

// File: tb/tb_mem_access_aligner.sv
// Directed bench for mem_access_aligner: a 32-bit instance for lane/extension/exception/reset cases
// and a 64-bit instance for dword and word-extension cases.
module tb_mem_access_aligner;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 32-bit instance
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, exc_valid, exc_store;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  // 64-bit instance
  logic        d_req_valid, d_req_ready, d_req_we, d_req_sign;
  logic [1:0]  d_req_size;
  logic [31:0] d_req_addr;
  logic [63:0] d_req_wdata;
  logic        d_rsp_valid, d_exc_valid, d_exc_store;
  logic [63:0] d_rsp_rdata;
  logic        d_mem_valid, d_mem_ready, d_mem_we;
  logic [31:0] d_mem_addr;
  logic [63:0] d_mem_wdata, d_mem_rdata;
  logic [7:0]  d_mem_be;

  mem_access_aligner #(.DATA_W(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .exc_valid(exc_valid), .exc_store(exc_store),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_access_aligner #(.DATA_W(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst(rst),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(d_req_we), .req_size(d_req_size),
    .req_sign(d_req_sign), .req_addr(d_req_addr), .req_wdata(d_req_wdata),
    .rsp_valid(d_rsp_valid), .rsp_rdata(d_rsp_rdata), .exc_valid(d_exc_valid), .exc_store(d_exc_store),
    .mem_valid(d_mem_valid), .mem_ready(d_mem_ready), .mem_we(d_mem_we), .mem_addr(d_mem_addr),
    .mem_be(d_mem_be), .mem_wdata(d_mem_wdata), .mem_rdata(d_mem_rdata)
  );

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
    tests++; if (mem_be !== 4'b0) begin fails++; $display("FAIL reset_mem_be got %b want 0000", mem_be); end
    tests++; if (rsp_valid !== 1'b0 || exc_valid !== 1'b0) begin fails++; $display("FAIL reset_pulses got rsp=%b exc=%b want 0 0", rsp_valid, exc_valid); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    tests++; if (d_req_ready !== 1'b1 || d_mem_valid !== 1'b0) begin fails++; $display("FAIL reset_u64 got ready=%b valid=%b want 1 0", d_req_ready, d_mem_valid); end
    rst = 1'b0;
  endtask

  // size, sign, addr, rdata, aligned addr, be, expected result
  task automatic test_loads;
    logic [1:0]  t_size [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic        t_sign [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_addr [5] = '{32'h1001, 32'h1002, 32'h1004, 32'h1008, 32'h1003};
    logic [31:0] t_rd   [5] = '{32'h0000_F500, 32'h8001_0000, 32'h8765_4321, 32'hDEAD_BEEF, 32'h80FF_1234};
    logic [31:0] t_al   [5] = '{32'h1000, 32'h1000, 32'h1004, 32'h1008, 32'h1000};
    logic [3:0]  t_be   [5] = '{4'b0010, 4'b1100, 4'b1111, 4'b1111, 4'b1000};
    logic [31:0] t_exp  [5] = '{32'h0000_00F5, 32'hFFFF_8001, 32'h8765_4321, 32'hDEAD_BEEF, 32'hFFFF_FF80};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = t_size[i]; req_sign = t_sign[i];
      req_addr = t_addr[i]; mem_ready = 1'b1; mem_rdata = t_rd[i];
      @(negedge clk);
      req_valid = 1'b0;
      tests++; if (mem_valid !== 1'b1 || mem_we !== 1'b0) begin fails++; $display("FAIL load%0d_beat got valid=%b we=%b want 1 0", i, mem_valid, mem_we); end
      tests++; if (mem_addr !== t_al[i]) begin fails++; $display("FAIL load%0d_addr got %h want %h", i, mem_addr, t_al[i]); end
      tests++; if (mem_be !== t_be[i]) begin fails++; $display("FAIL load%0d_be got %b want %b", i, mem_be, t_be[i]); end
      @(negedge clk);
      tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== t_exp[i]) begin fails++; $display("FAIL load%0d_rsp got v=%b d=%h want 1 %h", i, rsp_valid, rsp_rdata, t_exp[i]); end
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_store_half;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_sign = 1'b0;
    req_addr = 32'h2002; req_wdata = 32'h0000_ABCD; mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    tests++; if (mem_valid !== 1'b1 || mem_we !== 1'b1) begin fails++; $display("FAIL sh_beat got valid=%b we=%b want 1 1", mem_valid, mem_we); end
    tests++; if (mem_addr !== 32'h2000 || mem_be !== 4'b1100) begin fails++; $display("FAIL sh_lanes got addr=%h be=%b want 2000 1100", mem_addr, mem_be); end
    tests++; if (mem_wdata !== 32'hABCD_0000) begin fails++; $display("FAIL sh_wdata got %h want abcd0000", mem_wdata); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0 || mem_wdata !== 32'hABCD_0000 || req_ready !== 1'b0) begin fails++; $display("FAIL sh_stall got rsp=%b wdata=%h ready=%b want 0 abcd0000 0", rsp_valid, mem_wdata, req_ready); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL sh_rsp got %b want 1", rsp_valid); end
    tests++; if (rsp_rdata !== 32'hFFFF_FF80) begin fails++; $display("FAIL sh_rdata_held got %h want ffffff80", rsp_rdata); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL sh_done got rsp=%b ready=%b want 0 1", rsp_valid, req_ready); end
  endtask

`ifdef ALIGNER_MISALIGN_SPLIT_EN
  task automatic test_misalign;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_sign = 1'b0;
    req_addr = 32'h3003; mem_ready = 1'b1; mem_rdata = 32'hAA00_0000;
    @(negedge clk);
    req_valid = 1'b0;
    tests++; if (mem_valid !== 1'b1 || mem_be !== 4'b1000 || mem_addr !== 32'h3000) begin fails++; $display("FAIL split_beat0 got v=%b be=%b a=%h want 1 1000 3000", mem_valid, mem_be, mem_addr); end
    @(negedge clk);
    mem_rdata = 32'h00CC_BBDD;
    tests++; if (mem_valid !== 1'b1 || mem_be !== 4'b0111 || mem_addr !== 32'h3004) begin fails++; $display("FAIL split_beat1 got v=%b be=%b a=%h want 1 0111 3004", mem_valid, mem_be, mem_addr); end
    @(negedge clk);
    mem_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCCBB_DDAA) begin fails++; $display("FAIL split_rsp got v=%b d=%h want 1 ccbbddaa", rsp_valid, rsp_rdata); end
    tests++; if (exc_valid !== 1'b0) begin fails++; $display("FAIL split_no_exc got %b want 0", exc_valid); end
  endtask
`else
  task automatic test_misalign;
    logic [1:0]  t_size [3] = '{2'd2, 2'd2, 2'd1};
    logic        t_we   [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] t_addr [3] = '{32'h3001, 32'h3002, 32'h3003};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = t_we[i]; req_size = t_size[i]; req_addr = t_addr[i];
      req_wdata = 32'h5555_5555; mem_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      tests++; if (exc_valid !== 1'b1 || exc_store !== t_we[i]) begin fails++; $display("FAIL exc%0d got v=%b store=%b want 1 %b", i, exc_valid, exc_store, t_we[i]); end
      tests++; if (mem_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL exc%0d_side got mv=%b rdy=%b rsp=%b want 0 1 0", i, mem_valid, req_ready, rsp_valid); end
      @(negedge clk);
      tests++; if (exc_valid !== 1'b0 || mem_valid !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL exc%0d_after got exc=%b mv=%b rsp=%b want 0 0 0", i, exc_valid, mem_valid, rsp_valid); end
    end
    mem_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_midbeat;
    int pulses;
    bit seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_wdata = 32'h1234_5678; mem_ready = 1'b0;
`ifdef ALIGNER_MISALIGN_SPLIT_EN
    req_addr = 32'h5002;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    tests++; if (mem_valid !== 1'b1 || mem_be !== 4'b0011) begin fails++; $display("FAIL rst_pre_beat1 got v=%b be=%b want 1 0011", mem_valid, mem_be); end
`else
    req_addr = 32'h5000;
    @(negedge clk);
    req_valid = 1'b0;
    tests++; if (mem_valid !== 1'b1 || mem_be !== 4'b1111) begin fails++; $display("FAIL rst_pre_beat0 got v=%b be=%b want 1 1111", mem_valid, mem_be); end
`endif
    rst = 1'b1;
    #1;
    tests++; if (mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'b0) begin fails++; $display("FAIL rst_mid_ctrl got v=%b we=%b be=%b want 0 0 0000", mem_valid, mem_we, mem_be); end
    tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_mid_bus got a=%h d=%h want 0 0", mem_addr, mem_wdata); end
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin fails++; $display("FAIL rst_mid_rsp got rdy=%b rsp=%b d=%h want 1 0 0", req_ready, rsp_valid, rsp_rdata); end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL rst_abandoned got %0d rsp pulses want 0", pulses); end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_sign = 1'b0; req_addr = 32'h6000; mem_rdata = 32'h1122_3344;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    tests++; if (!seen) begin fails++; $display("FAIL rst_next_req got no rsp_valid want one within 10 cycles"); end
    tests++; if (rsp_rdata !== 32'h1122_3344) begin fails++; $display("FAIL rst_next_data got %h want 11223344", rsp_rdata); end
    mem_ready = 1'b0;
  endtask

  task automatic test_dword_stall;
    int pulses;
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_size = 2'd3; d_req_sign = 1'b0; d_req_addr = 32'h40;
    d_req_wdata = 64'h0123_4567_89AB_CDEF; d_mem_ready = 1'b0; d_mem_rdata = 64'h8000_0000_0000_0001;
    @(negedge clk);
    d_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (d_mem_valid !== 1'b1 || d_mem_be !== 8'hFF || d_mem_addr !== 32'h40 || d_mem_we !== 1'b0 ||
          d_mem_wdata !== 64'h0123_4567_89AB_CDEF || d_rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL ld_stall%0d got v=%b be=%h a=%h we=%b d=%h rsp=%b want 1 ff 40 0 0123456789abcdef 0",
                 i, d_mem_valid, d_mem_be, d_mem_addr, d_mem_we, d_mem_wdata, d_rsp_valid);
      end
      if (i == 4) d_mem_ready = 1'b1;
      @(negedge clk);
    end
    d_mem_ready = 1'b0;
    tests++; if (d_rsp_rdata !== 64'h8000_0000_0000_0001) begin fails++; $display("FAIL ld_data got %h want 8000000000000001", d_rsp_rdata); end
    pulses = 0;
    repeat (4) begin
      if (d_rsp_valid === 1'b1) pulses++;
      @(negedge clk);
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL ld_single_pulse got %0d want 1", pulses); end
  endtask

  task automatic test_word_on_64;
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_size = 2'd2; d_req_sign = 1'b1; d_req_addr = 32'h44;
    d_mem_ready = 1'b1; d_mem_rdata = 64'h8765_4321_0000_0000;
    @(negedge clk);
    d_req_valid = 1'b0;
    tests++; if (d_mem_be !== 8'hF0 || d_mem_addr !== 32'h40) begin fails++; $display("FAIL lw64_lanes got be=%h a=%h want f0 40", d_mem_be, d_mem_addr); end
    @(negedge clk);
    d_mem_ready = 1'b0;
    tests++; if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== 64'hFFFF_FFFF_8765_4321) begin fails++; $display("FAIL lw64_rsp got v=%b d=%h want 1 ffffffff87654321", d_rsp_valid, d_rsp_rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_size = 2'd0; d_req_sign = 1'b0;
    d_req_addr = '0; d_req_wdata = '0; d_mem_ready = 1'b0; d_mem_rdata = '0;
    test_reset();
    test_loads();
    test_store_half();
    test_misalign();
    test_reset_midbeat();
    test_dword_stall();
    test_word_on_64();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
